// File: rtl/idma_mc_req_arbiter.sv
// Multi-channel iDMA request arbiter: shares one backend among NumChannels frontends and
// routes in-order backend responses back to the issuing channel via a route FIFO.
module idma_mc_req_arbiter #(
    parameter int unsigned NumChannels  = 4,
    parameter int unsigned PendingDepth = 8,
    parameter int unsigned ArbMode      = 0,
    parameter type         idma_req_t   = logic,
    parameter type         idma_rsp_t   = logic,
    parameter int unsigned ChIdWidth    = (NumChannels > 1) ? $clog2(NumChannels) : 1,
    parameter int unsigned CntWidth     = $clog2(PendingDepth + 1)
) (
    input  logic                                  clk_i,
    input  logic                                  rst_i,
    input  logic      [NumChannels-1:0]           ch_enable_i,
    input  idma_req_t [NumChannels-1:0]           ch_req_i,
    input  logic      [NumChannels-1:0]           ch_req_valid_i,
    output logic      [NumChannels-1:0]           ch_req_ready_o,
    output idma_rsp_t [NumChannels-1:0]           ch_rsp_o,
    output logic      [NumChannels-1:0]           ch_rsp_valid_o,
    input  logic      [NumChannels-1:0]           ch_rsp_ready_i,
    output idma_req_t                             be_req_o,
    output logic                                  be_req_valid_o,
    input  logic                                  be_req_ready_i,
    input  idma_rsp_t                             be_rsp_i,
    input  logic                                  be_rsp_valid_i,
    output logic                                  be_rsp_ready_o,
    output logic      [NumChannels-1:0]           ch_busy_o,
    output logic      [NumChannels-1:0][CntWidth-1:0] ch_outstanding_o,
    output logic                                  pending_full_o,
    output logic                                  err_o
);

    localparam int unsigned PtrWidth = (PendingDepth > 1) ? $clog2(PendingDepth) : 1;
    localparam logic [CntWidth-1:0]  DepthCnt = CntWidth'(PendingDepth);
    localparam logic [ChIdWidth-1:0] LastCh   = ChIdWidth'(NumChannels - 1);
    localparam logic [PtrWidth-1:0]  LastPtr  = PtrWidth'(PendingDepth - 1);

    logic [ChIdWidth-1:0] route_q [PendingDepth];
    logic [PtrWidth-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CntWidth-1:0]  fill_q, fill_d;
    logic [ChIdWidth-1:0] rr_q, rr_d, lock_idx_q, lock_idx_d;
    logic                 lock_q, lock_d, err_q, err_d;
    logic [NumChannels-1:0][CntWidth-1:0] out_q, out_d;
    logic [NumChannels-1:0] busy_q, busy_d, inc, dec;

    logic [NumChannels-1:0] eligible;
    logic                   gnt_valid, full, empty, push, pop;
    logic [ChIdWidth-1:0]   gnt_idx, head;

    assign full     = (fill_q == DepthCnt);
    assign empty    = (fill_q == '0);
    assign eligible = ch_req_valid_i & ch_enable_i;
    assign head     = route_q[rd_ptr_q];

    // A locked grant bypasses eligibility so the backend never sees a retracted valid.
    always_comb begin
        int unsigned cand;
        cand      = 0;
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        if (lock_q) begin
            gnt_valid = 1'b1;
            gnt_idx   = lock_idx_q;
        end else if (!full) begin
            for (int unsigned i = 0; i < NumChannels; i++) begin
                if (ArbMode == 0) begin
                    cand = 32'(rr_q) + i;
                    if (cand >= NumChannels) cand = cand - NumChannels;
                end else begin
                    cand = i;
                end
                if (!gnt_valid && eligible[ChIdWidth'(cand)]) begin
                    gnt_valid = 1'b1;
                    gnt_idx   = ChIdWidth'(cand);
                end
            end
        end
    end

    assign be_req_o       = ch_req_i[gnt_idx];
    assign be_req_valid_o = gnt_valid;
    assign push           = gnt_valid & be_req_ready_i;

    always_comb begin
        ch_req_ready_o = '0;
        if (gnt_valid) ch_req_ready_o[gnt_idx] = be_req_ready_i;
    end

    always_comb begin
        ch_rsp_valid_o = '0;
        for (int k = 0; k < NumChannels; k++) ch_rsp_o[k] = be_rsp_i;
        if (!empty) ch_rsp_valid_o[head] = be_rsp_valid_i;
    end

    assign be_rsp_ready_o = !empty && ch_rsp_ready_i[head];
    assign pop            = be_rsp_valid_i & be_rsp_ready_o;

    always_comb begin
        lock_d     = gnt_valid & ~be_req_ready_i;
        lock_idx_d = gnt_idx;
        rr_d       = rr_q;
        if (push && (ArbMode == 0)) rr_d = (gnt_idx == LastCh) ? '0 : gnt_idx + 1'b1;

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        fill_d   = fill_q;
        if (push) wr_ptr_d = (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + 1'b1;
        if (push && !pop)      fill_d = fill_q + 1'b1;
        else if (pop && !push) fill_d = fill_q - 1'b1;

        err_d = err_q | (be_rsp_valid_i & empty);

        for (int k = 0; k < NumChannels; k++) begin
            inc[k]   = push && (gnt_idx == ChIdWidth'(k));
            dec[k]   = pop && (head == ChIdWidth'(k));
            out_d[k] = out_q[k];
            if (inc[k] && !dec[k])      out_d[k] = out_q[k] + 1'b1;
            else if (dec[k] && !inc[k]) out_d[k] = out_q[k] - 1'b1;
            busy_d[k] = (out_d[k] != '0);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fill_q     <= '0;
            rr_q       <= '0;
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
            err_q      <= 1'b0;
            out_q      <= '0;
            busy_q     <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            fill_q     <= fill_d;
            rr_q       <= rr_d;
            lock_q     <= lock_d;
            lock_idx_q <= lock_idx_d;
            err_q      <= err_d;
            out_q      <= out_d;
            busy_q     <= busy_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) route_q[wr_ptr_q] <= gnt_idx;
    end

    assign ch_busy_o        = busy_q;
    assign ch_outstanding_o = out_q;
    assign pending_full_o   = full;
    assign err_o            = err_q;

`ifndef SYNTHESIS
    for (genvar k = 0; k < NumChannels; k++) begin : g_cnt_chk
        assert property (@(posedge clk_i) disable iff (rst_i)
            !(inc[k] && !dec[k] && (out_q[k] == DepthCnt)));
        assert property (@(posedge clk_i) disable iff (rst_i)
            !(dec[k] && !inc[k] && (out_q[k] == '0)));
    end
`endif

endmodule

// File: doc/idma_mc_req_arbiter.md
Name: idma_mc_req_arbiter

Overview:
- Multi-channel successor to the single descriptor-frontend/backend pairing.
- Arbitrates NumChannels independent iDMA request streams (descriptor frontends, register frontends) onto one shared iDMA backend.
- Tracks every issued request in an in-order route FIFO so each backend response returns to the channel that issued it.
- Provides per-channel busy/outstanding status and channel enables for interrupt and status logic.

Parameters:
- NumChannels, 4, number of frontend channels (>=1).
- PendingDepth, 8, route FIFO depth = max backend requests outstanding (set to backend depth).
- ArbMode, 0, 0 = round-robin, 1 = fixed priority (lowest index wins).
- idma_req_t, logic, iDMA request struct type.
- idma_rsp_t, logic, iDMA response struct type.
- ChIdWidth, (NumChannels>1 ? $clog2(NumChannels) : 1), channel index width (do not override).
- CntWidth, $clog2(PendingDepth+1), outstanding-counter width (do not override).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, synchronous, active-high
- ch_enable_i  in  NumChannels  per-channel arbitration enable
- ch_req_i  in  NumChannels x idma_req_t  channel requests
- ch_req_valid_i  in  NumChannels  request valid
- ch_req_ready_o  out  NumChannels  request ready
- ch_rsp_o  out  NumChannels x idma_rsp_t  routed responses
- ch_rsp_valid_o  out  NumChannels  response valid
- ch_rsp_ready_i  in  NumChannels  response ready
- be_req_o  out  idma_req_t  request to backend
- be_req_valid_o  out  1  backend request valid
- be_req_ready_i  in  1  backend request ready
- be_rsp_i  in  idma_rsp_t  backend response
- be_rsp_valid_i  in  1  backend response valid
- be_rsp_ready_o  out  1  backend response ready
- ch_busy_o  out  NumChannels  channel has >=1 outstanding request
- ch_outstanding_o  out  NumChannels x CntWidth  outstanding count per channel
- pending_full_o  out  1  route FIFO full
- err_o  out  1  sticky: response arrived with route FIFO empty

Behaviour:
- Reset (synchronous, rst_i=1 at clk_i edge): route FIFO empty, all counters 0, RR pointer 0, lock cleared, err_o=0. Outputs after reset: be_req_valid_o=0, ch_req_ready_o=0, ch_rsp_valid_o=0, be_rsp_ready_o=0, ch_busy_o=0, pending_full_o=0. A reset mid-transfer discards all routing state; backend and frontends are reset together.
- Eligibility: channel k is eligible when ch_req_valid_i[k] & ch_enable_i[k].
- Grant selection (unlocked, FIFO not full):
  - ArbMode 0: first eligible index at or after the RR pointer, wrapping modulo NumChannels.
  - ArbMode 1: lowest eligible index.
- Request path is combinational, zero latency: be_req_o = ch_req_i[g], be_req_valid_o = 1, ch_req_ready_o[g] = be_req_ready_i. All other ready bits are 0.
- Lock: if be_req_valid_o=1 and be_req_ready_i=0, the lock register holds g until the handshake.
  - While locked, g does not change even if a higher-priority channel becomes eligible or ch_enable_i[g] drops; the valid is never retracted.
  - Lock clears on the handshake.
- Handshake (be_req_valid_o & be_req_ready_i): push g into the route FIFO, increment outstanding[g]. In ArbMode 0, RR pointer <= (g+1) mod NumChannels.
- FIFO full: no new grant, be_req_valid_o=0, all ch_req_ready_o=0. A locked grant cannot exist while full, since the lock is only taken when not full.
- Response routing uses head h of the route FIFO: ch_rsp_o[h] = be_rsp_i, ch_rsp_valid_o[h] = be_rsp_valid_i & !empty, be_rsp_ready_o = ch_rsp_ready_i[h] & !empty. Responses return strictly in issue order.
  - ch_rsp_o[k] for k != h is driven with be_rsp_i; its valid is 0.
- Response handshake: pop the FIFO, decrement outstanding[h].
- Same-cycle push and pop are both allowed, including when the FIFO is full (pop frees the slot next cycle; a push in the same cycle as full is not accepted).
  - Same channel pushed and popped in one cycle: its count is unchanged.
- be_rsp_valid_i while FIFO empty: be_rsp_ready_o=0 (stall), err_o set, sticky until reset.
- ch_busy_o[k] = (outstanding[k] != 0), registered. ch_outstanding_o = counter value. pending_full_o = FIFO count == PendingDepth.
- Counters saturate-check with a simulation assertion only: no increment past PendingDepth, no decrement below 0.

Test Plan:
- Round-robin fairness: ArbMode 0, channels 0-3 all valid, be_req_ready_i=1 → grant order 0,1,2,3,0; each count increments by 1 per grant.
- Fixed priority with lock: ArbMode 1, ch2 valid, backend ready=0 for 3 cycles, ch0 raises valid in cycle 1 → ch2 stays granted until handshake; ch0 is granted next cycle.
- Response routing: issue ch1, ch3, ch1; return 3 responses → delivered to ch1, ch3, ch1 in order. Counts go ch1 2→1→0, ch3 1→0; ch_busy_o clears.
- Full/backpressure: PendingDepth=8, 8 grants with no responses → pending_full_o=1, be_req_valid_o=0. One response pop and a pending request in the same cycle → that request is granted the next cycle.
- Response stall: hold ch_rsp_ready_i[head]=0 for 5 cycles → be_rsp_ready_o=0 and the FIFO is unchanged. Spurious be_rsp_valid_i with FIFO empty → err_o=1 and it stays set.
- Reset mid-operation: assert rst_i with 5 requests outstanding → next cycle all counters 0, FIFO empty, RR pointer 0, ch_busy_o=0.
